// File: rtl/sub_divider4.sv
// sub_divider4: sequential 4-bit unsigned divider (quotient/remainder by repeated subtraction).
// Define DIV_CYCLE_CNT_EN to add the 'cyc' output counting SUB cycles of the last operation.

module sub_divider4_fsub (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic d,
  output logic co
);
  // Adder form of a - b: carry out high means no borrow.
  assign d  = a ^ ~b ^ ci;
  assign co = (a & ~b) | (ci & ~(a ^ b));
endmodule

module sub_divider4 #(
  parameter logic [3:0] DBZ_Q = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       dbz
`ifdef DIV_CYCLE_CNT_EN
  ,output logic [4:0] cyc
`endif
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] div_q, div_d;
  logic [3:0] quo_q, quo_d;
  logic       dbz_q, dbz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef DIV_CYCLE_CNT_EN
  logic [4:0] cyc_q, cyc_d;
`endif

  logic [3:0] diff;
  logic [4:0] carry;
  logic       bout;

  assign carry[0] = 1'b1;
  assign bout     = carry[4];

  for (genvar i = 0; i < 4; i++) begin : g_bit
    sub_divider4_fsub u_fsub (
      .a  (rem_q[i]),
      .b  (div_q[i]),
      .ci (carry[i]),
      .d  (diff[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;
`ifdef DIV_CYCLE_CNT_EN
    cyc_d   = cyc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = A;
          div_d = B;
          quo_d = 4'd0;
          dbz_d = 1'b0;
`ifdef DIV_CYCLE_CNT_EN
          cyc_d = 5'd0;
`endif
          if (B == 4'd0) begin
            dbz_d   = 1'b1;
            quo_d   = DBZ_Q;
            state_d = DONE;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
`ifdef DIV_CYCLE_CNT_EN
        cyc_d = cyc_q + 5'd1;
`endif
        if (bout) begin
          rem_d = diff;
          quo_d = quo_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      div_q   <= 4'd0;
      quo_q   <= 4'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_CYCLE_CNT_EN
      cyc_q   <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_CYCLE_CNT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign Q    = quo_q;
  assign R    = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
`ifdef DIV_CYCLE_CNT_EN
  assign cyc  = cyc_q;
`endif

endmodule

// File: tb/tb_sub_divider4.sv
// Bench for sub_divider4: arithmetic reference model checked every cycle, plus directed
// operations with hand-computed quotient, remainder, flag and latency.

module tb_sub_divider4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = 4'd0;
  logic [3:0] B = 4'd0;
  logic [3:0] Q, R;
  logic       busy, done, dbz;
`ifdef DIV_CYCLE_CNT_EN
  logic [4:0] cyc;
`endif

  int checks = 0;
  int errors = 0;

  sub_divider4 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
`ifdef DIV_CYCLE_CNT_EN
    ,.cyc  (cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: each accepted operation fixes its result and the edge index
  // at which its done cycle begins; busy spans acceptance through that cycle.
  int         edge_n    = 0;
  int         done_edge = -100;
  logic [3:0] m_q = 4'd0, m_r = 4'd0;
  logic       m_dbz = 1'b0;
  int         m_cyc = 0;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst) begin
      m_valid   <= 1'b1;
      done_edge <= -100;
      m_q       <= 4'd0;
      m_r       <= 4'd0;
      m_dbz     <= 1'b0;
      m_cyc     <= 0;
    end else if (start && (edge_n + 1 >= done_edge + 2)) begin
      if (B == 4'd0) begin
        done_edge <= edge_n + 1;
        m_q       <= 4'hF;
        m_r       <= A;
        m_dbz     <= 1'b1;
        m_cyc     <= 0;
      end else begin
        done_edge <= edge_n + 2 + int'(A / B);
        m_q       <= A / B;
        m_r       <= A % B;
        m_dbz     <= 1'b0;
        m_cyc     <= int'(A / B) + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_busy", int'(busy), int'(edge_n <= done_edge));
      chk("m_done", int'(done), int'(edge_n == done_edge));
      if (edge_n >= done_edge) begin
        chk("m_Q", int'(Q), int'(m_q));
        chk("m_R", int'(R), int'(m_r));
        chk("m_dbz", int'(dbz), int'(m_dbz));
`ifdef DIV_CYCLE_CNT_EN
        chk("m_cyc", int'(cyc), m_cyc);
`endif
      end
    end
  end

  // Waits for done, counting posedges from the cycle in which start was driven.
  task automatic wait_done(input string nm, input bit hold, input int exp_lat,
                           input int exp_q, input int exp_r, input int exp_dbz);
    int  lat = 0;
    bit  got = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_Q"}, int'(Q), exp_q);
    chk({nm, "_R"}, int'(R), exp_r);
    chk({nm, "_dbz"}, int'(dbz), exp_dbz);
  endtask

  task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input int exp_lat, input int exp_q, input int exp_r, input int exp_dbz);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    wait_done(nm, 1'b0, exp_lat, exp_q, exp_r, exp_dbz);
  endtask

  initial begin
    // Reset held for two edges while a start request is presented.
    rst = 1'b1; start = 1'b1; A = 4'd9; B = 4'd2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_Q", int'(Q), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(dbz), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);

    run_op("d13_4", 4'd13, 4'd4, 5, 3, 1, 0);
`ifdef DIV_CYCLE_CNT_EN
    chk("d13_4_cyc", int'(cyc), 4);
`endif
    run_op("d15_1", 4'd15, 4'd1, 17, 15, 0, 0);
`ifdef DIV_CYCLE_CNT_EN
    chk("d15_1_cyc", int'(cyc), 16);
`endif
    run_op("d3_5", 4'd3, 4'd5, 2, 0, 3, 0);
    run_op("d0_7", 4'd0, 4'd7, 2, 0, 0, 0);
    run_op("d9_0", 4'd9, 4'd0, 1, 15, 9, 1);
`ifdef DIV_CYCLE_CNT_EN
    chk("d9_0_cyc", int'(cyc), 0);
`endif
    run_op("d6_3", 4'd6, 4'd3, 4, 2, 0, 0);
    run_op("d15_15", 4'd15, 4'd15, 3, 1, 0, 0);

    // start held high: operands changed during DONE are taken on the next IDLE cycle.
    @(negedge clk);
    start = 1'b1; A = 4'd14; B = 4'd3;
    wait_done("hold1", 1'b1, 6, 4, 2, 0);
    A = 4'd5; B = 4'd5;
    wait_done("hold2", 1'b1, 4, 1, 0, 0);
    start = 1'b0;

    // Operand changes and start pulses mid-operation are ignored.
    @(negedge clk);
    start = 1'b1; A = 4'd11; B = 4'd2;
    @(negedge clk);
    start = 1'b0; A = 4'd1; B = 4'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 1'b0, 4, 5, 1, 0);

    // Reset sampled at the edge ending the third SUB cycle of 15/2.
    @(negedge clk);
    start = 1'b1; A = 4'd15; B = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_Q", int'(Q), 0);
    chk("abort_R", int'(R), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    run_op("d7_7", 4'd7, 4'd7, 3, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
